mem_stage: RTL and testbench

//  Pipeline MEM stage plus MEM/WB register. Consumes EX/MEM register outputs, performs data-memory

---
 rtl/mem_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage plus MEM/WB register.
//  Issues data-memory loads/stores over a req/ready handshake, stalls the pipe while an access is
//  outstanding, aborts after TIMEOUT_CYC cycles without mem_ready, and registers write-back operands.
//  Optional feature macro: MEM_MISALIGN_TRAP_EN (word access with addr[1:0]!=0 traps instead of
//  issuing a request).
// Ports:
//  clk, rst_b                     clock, asynchronous active-low reset
//  mem_write_en .. rd_num         EX/MEM register outputs (control, address/ALU value, store data)
//  mem_addr/wdata/we/size/req     data-memory request (combinational, held for the whole access)
//  mem_ready, mem_rdata           data-memory completion and read data
//  stall                          freeze upstream pipe registers this cycle
//  mem_err                        one-cycle pulse on timeout or misalign trap
//  wb_*                           MEM/WB register outputs
module mem_stage #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            mem_write_en,
  input  logic            mem_to_reg,
  input  logic            reg_write,
  input  logic            is_mem_inst,
  input  logic            is_word,
  input  logic            halted,
  input  logic [31:0]     alu_result,
  input  logic [3:0][7:0] read_data_2,
  input  logic [4:0]      rd_num,
  output logic [31:0]     mem_addr,
  output logic [3:0][7:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_size,
  output logic            mem_req,
  input  logic            mem_ready,
  input  logic [3:0][7:0] mem_rdata,
  output logic            stall,
  output logic            mem_err,
  output logic            wb_reg_write,
  output logic            wb_mem_to_reg,
  output logic [4:0]      wb_rd_num,
  output logic [31:0]     wb_alu_result,
  output logic [31:0]     wb_load_data,
  output logic            wb_halted
);

  localparam int unsigned LANE_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0][7:0]  wdata_q, wdata_d;
  logic [3:0][7:0]  rdata_q, rdata_d;
  logic             we_q, we_d;
  logic             size_q, size_d;
  logic             tout_q, tout_d;
  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic [4:0]       rd_q, rd_d;

  logic             wb_reg_write_q, wb_reg_write_d;
  logic             wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]       wb_rd_num_q, wb_rd_num_d;
  logic [31:0]      wb_alu_result_q, wb_alu_result_d;
  logic [31:0]      wb_load_data_q, wb_load_data_d;
  logic             wb_halted_q, wb_halted_d;

  logic             req_c, stall_c, err_c, misalign_c;
  logic [3:0][7:0]  wdata_in_c;
  logic [LANE_W-1:0] byte_c;
  logic [31:0]      load_c;

  // Store data: word passes through, byte is steered to its address lane
  always_comb begin
    wdata_in_c = '0;
    if (is_word) begin
      wdata_in_c = read_data_2;
    end else begin
      wdata_in_c[alu_result[1:0]] = read_data_2[0];
    end
  end

  // Misaligned word access detection (only acted upon when the trap is built in)
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_c = is_word && (alu_result[1:0] != 2'b00);
`else
    misalign_c = 1'b0;
`endif
  end

  // Load data formatting from the captured read data
  always_comb begin
    byte_c = rdata_q[addr_q[1:0]];
    if (size_q) begin
      load_c = rdata_q;
    end else begin
      load_c = {{24{byte_c[LANE_W-1]}}, byte_c};
    end
  end

  // Next-state, access latching and MEM/WB load
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    we_d            = we_q;
    size_d          = size_q;
    tout_d          = tout_q;
    reg_write_d     = reg_write_q;
    mem_to_reg_d    = mem_to_reg_q;
    rd_d            = rd_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_rd_num_d     = wb_rd_num_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_load_data_d  = wb_load_data_q;
    wb_halted_d     = wb_halted_q;
    req_c           = 1'b0;
    stall_c         = 1'b0;
    err_c           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (is_mem_inst && !halted && misalign_c) begin
          // Trap: no request, halt the core through WB
          err_c           = 1'b1;
          wb_reg_write_d  = 1'b0;
          wb_mem_to_reg_d = mem_to_reg;
          wb_rd_num_d     = rd_num;
          wb_alu_result_d = alu_result;
          wb_load_data_d  = '0;
          wb_halted_d     = 1'b1;
        end else if (is_mem_inst && !halted) begin
          req_c        = 1'b1;
          stall_c      = 1'b1;
          addr_d       = alu_result;
          wdata_d      = wdata_in_c;
          we_d         = mem_write_en;
          size_d       = is_word;
          reg_write_d  = reg_write;
          mem_to_reg_d = mem_to_reg;
          rd_d         = rd_num;
          rdata_d      = '0;
          tout_d       = 1'b0;
          cnt_d        = '0;
          state_d      = ST_ACCESS;
        end else begin
          wb_reg_write_d  = reg_write;
          wb_mem_to_reg_d = mem_to_reg;
          wb_rd_num_d     = rd_num;
          wb_alu_result_d = alu_result;
          wb_load_data_d  = '0;
          wb_halted_d     = halted;
        end
      end

      ST_ACCESS: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Ready takes priority over a same-cycle timeout
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_c   = 1'b1;
          tout_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        wb_reg_write_d  = reg_write_q && !we_q && !tout_q;
        wb_mem_to_reg_d = mem_to_reg_q;
        wb_rd_num_d     = rd_q;
        wb_alu_result_d = addr_q;
        wb_load_data_d  = (we_q || tout_q) ? 32'h0 : load_c;
        wb_halted_d     = 1'b0;
        state_d         = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      rdata_q         <= '0;
      we_q            <= 1'b0;
      size_q          <= 1'b0;
      tout_q          <= 1'b0;
      reg_write_q     <= 1'b0;
      mem_to_reg_q    <= 1'b0;
      rd_q            <= '0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_num_q     <= '0;
      wb_alu_result_q <= '0;
      wb_load_data_q  <= '0;
      wb_halted_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      rdata_q         <= rdata_d;
      we_q            <= we_d;
      size_q          <= size_d;
      tout_q          <= tout_d;
      reg_write_q     <= reg_write_d;
      mem_to_reg_q    <= mem_to_reg_d;
      rd_q            <= rd_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_num_q     <= wb_rd_num_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_load_data_q  <= wb_load_data_d;
      wb_halted_q     <= wb_halted_d;
    end
  end

  // Handshake outputs are combinational; reset kills them immediately
  assign mem_req   = req_c && rst_b;
  assign stall     = stall_c && rst_b;
  assign mem_err   = err_c && rst_b;
  // In IDLE the request is issued straight from the inputs; afterwards from the latched copy
  assign mem_addr  = !mem_req ? 32'h0 : (state_q == ST_IDLE) ? alu_result : addr_q;
  assign mem_wdata = !mem_req ? '0 : (state_q == ST_IDLE) ? wdata_in_c : wdata_q;
  assign mem_we    = mem_req && ((state_q == ST_IDLE) ? mem_write_en : we_q);
  assign mem_size  = mem_req && ((state_q == ST_IDLE) ? is_word : size_q);

  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_rd_num     = wb_rd_num_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_load_data  = wb_load_data_q;
  assign wb_halted     = wb_halted_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (honours MEM_MISALIGN_TRAP_EN if defined).
module tb_mem_stage;

  logic            clk = 1'b0;
  logic            rst_b;
  logic            mem_write_en, mem_to_reg, reg_write, is_mem_inst, is_word, halted;
  logic [31:0]     alu_result;
  logic [3:0][7:0] read_data_2;
  logic [4:0]      rd_num;
  logic [31:0]     mem_addr;
  logic [3:0][7:0] mem_wdata;
  logic            mem_we, mem_size, mem_req, mem_ready;
  logic [3:0][7:0] mem_rdata;
  logic            stall, mem_err;
  logic            wb_reg_write, wb_mem_to_reg, wb_halted;
  logic [4:0]      wb_rd_num;
  logic [31:0]     wb_alu_result, wb_load_data;

  int n_cmp = 0;
  int n_err = 0;
  int stalls, errs, err_cyc, done_cyc;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .clk(clk), .rst_b(rst_b),
    .mem_write_en(mem_write_en), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .is_mem_inst(is_mem_inst), .is_word(is_word), .halted(halted),
    .alu_result(alu_result), .read_data_2(read_data_2), .rd_num(rd_num),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_size(mem_size),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall(stall), .mem_err(mem_err),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd_num(wb_rd_num),
    .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_halted(wb_halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic mem, input logic we, input logic word, input logic m2r,
                        input logic rw, input logic halt, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [4:0] rd);
    is_mem_inst  = mem;
    mem_write_en = we;
    is_word      = word;
    mem_to_reg   = m2r;
    reg_write    = rw;
    halted       = halt;
    alu_result   = alu;
    read_data_2  = wd;
    rd_num       = rd;
  endtask

  // Runs one access from IDLE (cycle 0) until the DONE cycle, then clocks the DONE edge and
  // parks the inputs on a nop. ready_at < 0 means memory never responds.
  task automatic run_mem(input int ready_at, input logic [31:0] rdata);
    stalls = 0; errs = 0; err_cyc = -1; done_cyc = -1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      mem_ready = (cyc == ready_at);
      mem_rdata = rdata;
      #1;
      if (stall) stalls++;
      if (mem_err) begin errs++; err_cyc = cyc; end
      if (!stall) begin done_cyc = cyc; break; end
      step();
    end
    mem_ready = 1'b0;
    step();
    set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    rst_b = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #3;
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_wb_alu", wb_alu_result, 32'h0);
    chk("rst_wb_rw", 32'(wb_reg_write), 32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    step();

    // Non-memory op: zero-latency pass-through
    set_op(0, 0, 1, 0, 1, 0, 32'h1234, 32'h0, 5'd5);
    #1;
    chk("nop_stall", 32'(stall), 32'h0);
    step();
    chk("nop_wb_alu", wb_alu_result, 32'h1234);
    chk("nop_wb_rd", 32'(wb_rd_num), 32'd5);
    chk("nop_wb_rw", 32'(wb_reg_write), 32'h1);
    chk("nop_wb_ld", wb_load_data, 32'h0);

    // lw 0x40, ready in the second ACCESS cycle
    set_op(1, 0, 1, 1, 1, 0, 32'h40, 32'h0, 5'd7);
    #1;
    chk("lw_req", 32'(mem_req), 32'h1);
    chk("lw_addr", mem_addr, 32'h40);
    chk("lw_size", 32'(mem_size), 32'h1);
    chk("lw_we", 32'(mem_we), 32'h0);
    run_mem(2, 32'hDEADBEEF);
    chk("lw_stalls", 32'(stalls), 32'd3);
    chk("lw_errs", 32'(errs), 32'd0);
    chk("lw_ld", wb_load_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(wb_rd_num), 32'd7);
    chk("lw_m2r", 32'(wb_mem_to_reg), 32'h1);
    chk("lw_rw", 32'(wb_reg_write), 32'h1);

    // lb 0x41: lane 1 = 0x80 sign-extends
    set_op(1, 0, 0, 1, 1, 0, 32'h41, 32'h0, 5'd8);
    run_mem(1, 32'h0000_8000);
    chk("lb_stalls", 32'(stalls), 32'd2);
    chk("lb_ld", wb_load_data, 32'hFFFFFF80);
    chk("lb_alu", wb_alu_result, 32'h41);

    // sb 0x42 data 0x5A -> lane 2
    set_op(1, 1, 0, 0, 1, 0, 32'h42, 32'h1122335A, 5'd9);
    #1;
    chk("sb_wdata", mem_wdata, 32'h005A0000);
    chk("sb_we", 32'(mem_we), 32'h1);
    chk("sb_size", 32'(mem_size), 32'h0);
    run_mem(1, 32'h0);
    chk("sb_rw", 32'(wb_reg_write), 32'h0);

    // Timeout: memory never answers
    set_op(1, 0, 1, 1, 1, 0, 32'h80, 32'h0, 5'd9);
    run_mem(-1, 32'h0);
    chk("to_errs", 32'(errs), 32'd1);
    chk("to_err_cyc", 32'(err_cyc), 32'd64);
    chk("to_done_cyc", 32'(done_cyc), 32'd65);
    chk("to_rw", 32'(wb_reg_write), 32'h0);
    chk("to_rd", 32'(wb_rd_num), 32'd9);

    // Reset in the middle of an access
    set_op(1, 0, 1, 1, 1, 0, 32'h44, 32'h0, 5'd10);
    step();
    chk("rm_req_pre", 32'(mem_req), 32'h1);
    rst_b = 1'b0;
    #1;
    chk("rm_req", 32'(mem_req), 32'h0);
    chk("rm_stall", 32'(stall), 32'h0);
    chk("rm_wb_alu", wb_alu_result, 32'h0);
    chk("rm_wb_rd", 32'(wb_rd_num), 32'd0);
    set_op(1, 0, 1, 1, 1, 0, 32'h48, 32'h0, 5'd11);
    #2;
    rst_b = 1'b1;
    run_mem(2, 32'h01020304);
    chk("rm2_stalls", 32'(stalls), 32'd3);
    chk("rm2_ld", wb_load_data, 32'h01020304);
    chk("rm2_rd", 32'(wb_rd_num), 32'd11);

    // Halted memory op passes through without an access
    set_op(1, 0, 1, 0, 1, 1, 32'h50, 32'h0, 5'd12);
    #1;
    chk("hlt_req", 32'(mem_req), 32'h0);
    chk("hlt_stall", 32'(stall), 32'h0);
    step();
    chk("hlt_wb_h", 32'(wb_halted), 32'h1);
    chk("hlt_wb_rd", 32'(wb_rd_num), 32'd12);
    set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    step();

    // Misaligned lw 0x43
    set_op(1, 0, 1, 1, 1, 0, 32'h43, 32'h0, 5'd13);
`ifdef MEM_MISALIGN_TRAP_EN
    #1;
    chk("mis_req", 32'(mem_req), 32'h0);
    chk("mis_err", 32'(mem_err), 32'h1);
    chk("mis_stall", 32'(stall), 32'h0);
    step();
    set_op(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    chk("mis_wb_h", 32'(wb_halted), 32'h1);
    chk("mis_wb_rw", 32'(wb_reg_write), 32'h0);
    #1;
    chk("mis_err_end", 32'(mem_err), 32'h0);
`else
    #1;
    chk("mis_req", 32'(mem_req), 32'h1);
    chk("mis_addr", mem_addr, 32'h43);
    run_mem(1, 32'hCAFEF00D);
    chk("mis_errs", 32'(errs), 32'd0);
    chk("mis_ld", wb_load_data, 32'hCAFEF00D);
    chk("mis_wb_h", 32'(wb_halted), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
